sound_gen: RTL
==============

SOUND_GEN -- requirements
Module: sound_gen

Interface
REQ-001 Parameter HALF_LO, default 56818, low-tone half-period in clk cycles (16-bit range, >=2).
REQ-002 Parameter HALF_HI, default 28409, high-tone half-period in clk cycles (16-bit range, >=2).
REQ-003 Parameter NOTE_LEN, default 2500000, note duration in clk cycles (24-bit range, >=1).
REQ-004 Parameter GAP_LEN, default 1250000, silent gap between the two notes of a two-note sound, in clk cycles (24-bit range, >=1).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 clr  input  1  reset, asynchronous and active-low.
REQ-007 code_sound  input  2  sound code from the logo block: 00 ping, 01 pong, 10 go, 11 stop.
REQ-008 mute  input  1  level; when 1, silences the speaker output.
REQ-009 speaker  output  1  square-wave drive for the buzzer.
REQ-010 busy  output  1  1 while a sound sequence is in progress, including the gap.

Function
REQ-011 The block SHALL register code_sound into code_q on every clock edge.
REQ-012 A trigger SHALL occur on any clock edge where code_sound != code_q. On that edge the FSM SHALL enter NOTE1 with the counters cleared and the sequence latched from code_sound.
REQ-013 FSM states SHALL be IDLE, NOTE1, GAP and NOTE2; busy = 1 in every state except IDLE.
REQ-014 Sequences:
- ping = NOTE1 high tone, then IDLE.
- pong = NOTE1 low tone, then IDLE.
- go = NOTE1 low, GAP, NOTE2 high.
- stop = NOTE1 high, GAP, NOTE2 low.
REQ-015 NOTE1 and NOTE2 SHALL each last exactly NOTE_LEN cycles, and GAP SHALL last exactly GAP_LEN cycles, counted by a shared 24-bit duration counter that is cleared on every state entry.
REQ-016 Transitions:
- From NOTE1 at end of duration: to GAP for go/stop, otherwise to IDLE.
- From GAP at end of duration: to NOTE2.
- From NOTE2 at end of duration: to IDLE.
REQ-017 Tone generation:
- A 16-bit half-period counter counts 0..HALF-1 during a note.
- At count HALF-1, the internal tone bit SHALL toggle and the counter SHALL return to 0.
- The tone bit SHALL be 0 on entry to each note.
REQ-018 speaker SHALL equal (tone bit AND state is NOTE1 or NOTE2 AND mute == 0), and SHALL be driven from a register with no combinational path from inputs.
REQ-019 Mute SHALL NOT stop or stretch the FSM or its counters. Only the speaker output is suppressed.
REQ-020 A trigger while busy SHALL abort the current sequence and restart at NOTE1 with the new code (latest wins). There SHALL be no extra idle cycle between the two sequences.
REQ-021 A trigger on the same edge as an end-of-duration transition SHALL take priority over that transition.
REQ-022 All counters SHALL be free of wrap-around. The duration counter SHALL never exceed its state length minus 1.

Reset
REQ-023 While clr = 0 the block SHALL hold: state IDLE, code_q = 00, tone bit = 0, all counters = 0, speaker = 0, busy = 0.
REQ-024 Release of clr SHALL take effect at the next rising clk edge. If code_sound != 00 at release, a trigger SHALL occur on that first edge.
REQ-025 Assertion of clr mid-sequence SHALL immediately force speaker = 0 and busy = 0 without waiting for a clock edge.

Verification
(Common parameters for all scenarios: HALF_LO=4, HALF_HI=2, NOTE_LEN=20, GAP_LEN=6.)
REQ-026 Pong: reset with code 00, then drive 01.
- busy = 1 for exactly 20 cycles.
- speaker toggles every 4 cycles starting low, i.e. 0000 1111 0000 1111 0000.
- Then speaker = 0 and busy = 0.
REQ-027 Go: drive 10 from idle.
- busy = 1 for exactly 46 cycles.
- Cycles 1-20: low tone (period 8).
- Cycles 21-26: speaker = 0.
- Cycles 27-46: high tone (period 4, 00110011...).
REQ-028 Restart: drive 11 (stop), then change to 00 on cycle 10 of NOTE1.
- On that edge the sequence restarts as ping.
- busy stays 1 continuously and stays high for a further 20 cycles.
- No GAP or NOTE2 occurs.
REQ-029 Mute: drive 00->01 with mute = 1 throughout.
- busy = 1 for 20 cycles, speaker = 0 throughout.
- Deassert mute at cycle 12: speaker resumes mid-waveform at the phase given by REQ-017.
REQ-030 Reset mid-sequence: pull clr low asynchronously during GAP of go.
- speaker = 0 and busy = 0 before the next clk edge.
- After release with code_sound = 00: no trigger, busy remains 0.
REQ-031 Stable code: hold code_sound = 01 constant for 100 cycles after one pong completes.
- No retrigger occurs; busy = 0 and speaker = 0 throughout.

Source files
------------

// File: rtl/sound_gen.sv
// Two-note buzzer sequencer: plays ping/pong/go/stop on any change of code_sound.
// A new code always restarts the sequence; mute only gates the speaker output.
module sound_gen #(
    parameter int unsigned HALF_LO  = 56818,
    parameter int unsigned HALF_HI  = 28409,
    parameter int unsigned NOTE_LEN = 2500000,
    parameter int unsigned GAP_LEN  = 1250000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       speaker,
    output logic       busy
);

    localparam logic [15:0] HALF_LO_LAST  = 16'(HALF_LO - 1);
    localparam logic [15:0] HALF_HI_LAST  = 16'(HALF_HI - 1);
    localparam logic [23:0] NOTE_LAST     = 24'(NOTE_LEN - 1);
    localparam logic [23:0] GAP_LAST      = 24'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NOTE1 = 2'd1,
        GAP   = 2'd2,
        NOTE2 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [1:0]  seq_q, seq_d;
    logic        tone_q, tone_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [23:0] dur_q, dur_d;
    logic        speaker_q, speaker_d;
    logic        busy_q, busy_d;

    logic        trigger;
    logic        dur_end;
    logic        note_hi;
    logic [15:0] half_last;

    always_comb begin
        state_d    = state_q;
        code_d     = code_sound;
        seq_d      = seq_q;
        tone_d     = tone_q;
        half_cnt_d = half_cnt_q;
        dur_d      = dur_q;

        trigger = (code_sound != code_q);
        dur_end = (dur_q == ((state_q == GAP) ? GAP_LAST : NOTE_LAST));

        // ping/stop open high, pong/go open low; only go ends high
        if (state_q == NOTE1) begin
            note_hi = (seq_q[1] == seq_q[0]);
        end else begin
            note_hi = (seq_q == 2'b10);
        end
        half_last = note_hi ? HALF_HI_LAST : HALF_LO_LAST;

        if (trigger) begin
            state_d    = NOTE1;
            seq_d      = code_sound;
            dur_d      = '0;
            half_cnt_d = '0;
            tone_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dur_d      = '0;
                    half_cnt_d = '0;
                    tone_d     = 1'b0;
                end
                NOTE1, NOTE2: begin
                    if (dur_end) begin
                        state_d    = (state_q == NOTE1 && seq_q[1]) ? GAP : IDLE;
                        dur_d      = '0;
                        half_cnt_d = '0;
                        tone_d     = 1'b0;
                    end else begin
                        dur_d = dur_q + 24'd1;
                        if (half_cnt_q == half_last) begin
                            half_cnt_d = '0;
                            tone_d     = ~tone_q;
                        end else begin
                            half_cnt_d = half_cnt_q + 16'd1;
                        end
                    end
                end
                GAP: begin
                    half_cnt_d = '0;
                    tone_d     = 1'b0;
                    if (dur_end) begin
                        state_d = NOTE2;
                        dur_d   = '0;
                    end else begin
                        dur_d = dur_q + 24'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    dur_d      = '0;
                    half_cnt_d = '0;
                    tone_d     = 1'b0;
                end
            endcase
        end

        // outputs follow the next state so they line up with the state register
        speaker_d = tone_d && (state_d == NOTE1 || state_d == NOTE2) && !mute;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            code_q     <= '0;
            seq_q      <= '0;
            tone_q     <= 1'b0;
            half_cnt_q <= '0;
            dur_q      <= '0;
            speaker_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            seq_q      <= seq_d;
            tone_q     <= tone_d;
            half_cnt_q <= half_cnt_d;
            dur_q      <= dur_d;
            speaker_q  <= speaker_d;
            busy_q     <= busy_d;
        end
    end

    assign speaker = speaker_q;
    assign busy    = busy_q;

endmodule
